// File: rtl/dest_reg_hazard_pkg.sv
// Shared constants and stage-entry layouts for the destination-register hazard unit.
// The entry structs are sized by REG_ADDR_W; the top's ADDR_W must equal it.
package dest_reg_hazard_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // valid is the MSB of every entry so a cleared entry is a bubble
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
    } dest_entry_t;

    typedef struct packed {
        dest_entry_t           base;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
    } ex_entry_t;

    localparam int DEST_ENTRY_W = $bits(dest_entry_t);
    localparam int EX_ENTRY_W   = $bits(ex_entry_t);

    // Register $0 is hard-wired, so an entry targeting it never produces a value.
    function automatic logic is_writing(input dest_entry_t e);
        return e.valid & e.reg_write & (e.dest != '0);
    endfunction

endpackage

// File: rtl/dest_reg_hazard_if.sv
// ID-stage request bundle and the hazard/forwarding/writeback responses.
// id_valid qualifies all id_* fields; while stall is high the ID side must hold them unchanged.
interface dest_reg_hazard_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [ADDR_W-1:0] id_dest;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;

    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [ADDR_W-1:0] wb_dest;
    logic              wb_we;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dest, id_reg_write, id_mem_read, flush,
        input  stall, fwd_a, fwd_b, wb_dest, wb_we, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dest, id_reg_write, id_mem_read, flush,
        output stall, fwd_a, fwd_b, wb_dest, wb_we, stall_count
    );
endinterface

// File: rtl/dest_reg_hazard_unit_stage.sv
// One pipeline entry register: async clear, load enable, and bubble insert (clears the entry).
module dest_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_bubble ? '0 : i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/dest_reg_hazard_unit.sv
// Tracks dest/reg_write/mem_read through EX, MEM, WB and derives the load-use stall,
// EX operand forwarding selects, register-file write port and a saturating stall counter.
module dest_reg_hazard_unit
    import dest_reg_hazard_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    dest_reg_hazard_if.slave bus
);
    logic [ADDR_W-1:0] w_id_rs;
    logic [ADDR_W-1:0] w_id_rt;
    logic [ADDR_W-1:0] w_id_dest;
    ex_entry_t         w_id_entry;
    ex_entry_t         w_ex;
    dest_entry_t       w_mem;
    dest_entry_t       w_wb;
    logic              w_ex_writing;
    logic              w_mem_writing;
    logic              w_wb_writing;
    logic              w_load_use;
    logic              w_stall;
    logic              w_ex_bubble;
    logic              w_illegal_a;
    logic              w_illegal_b;
    logic              w_unused_wb_mem_read;
    logic [CNT_W-1:0]  r_stall_count;

    assign w_id_rs   = bus.id_rs;
    assign w_id_rt   = bus.id_rt;
    assign w_id_dest = bus.id_dest;

    always_comb begin
        w_id_entry                = '0;
        w_id_entry.base.valid     = bus.id_valid;
        w_id_entry.base.dest      = w_id_dest;
        w_id_entry.base.reg_write = bus.id_reg_write;
        w_id_entry.base.mem_read  = bus.id_mem_read;
        w_id_entry.rs             = w_id_rs;
        w_id_entry.rt             = w_id_rt;
        w_id_entry.uses_rs        = bus.id_uses_rs;
        w_id_entry.uses_rt        = bus.id_uses_rt;
    end

    dest_pipe_stage #(.W(EX_ENTRY_W)) u_ex (
        .clk      (clk),
        .rst      (rst),
        .i_load   (1'b1),
        .i_bubble (w_ex_bubble),
        .i_d      (w_id_entry),
        .o_q      (w_ex)
    );

    dest_pipe_stage #(.W(DEST_ENTRY_W)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_d      (w_ex.base),
        .o_q      (w_mem)
    );

    dest_pipe_stage #(.W(DEST_ENTRY_W)) u_wb (
        .clk      (clk),
        .rst      (rst),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_d      (w_mem),
        .o_q      (w_wb)
    );

    assign w_ex_writing  = is_writing(w_ex.base);
    assign w_mem_writing = is_writing(w_mem);
    assign w_wb_writing  = is_writing(w_wb);

    // A load in EX has no data until the end of MEM, so a dependent in ID waits one cycle.
    assign w_load_use = bus.id_valid & w_ex_writing & w_ex.base.mem_read &
                        ((bus.id_uses_rs & (w_id_entry.rs == w_ex.base.dest)) |
                         (bus.id_uses_rt & (w_id_entry.rt == w_ex.base.dest)));
    assign w_stall     = w_load_use & ~bus.flush;
    assign w_ex_bubble = bus.flush | w_stall;

    // Youngest producer wins; a load still in MEM cannot be forwarded and selects the regfile.
    function automatic logic [1:0] fwd_sel(
        input logic                  ex_valid,
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mem_wr,
        input logic                  mem_ld,
        input logic [REG_ADDR_W-1:0] mem_dest,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_dest
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (ex_valid && uses) begin
            if (mem_wr && (mem_dest == src)) begin
                sel = mem_ld ? FWD_NONE : FWD_EXMEM;
            end else if (wb_wr && (wb_dest == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    assign bus.fwd_a = fwd_sel(w_ex.base.valid, w_ex.uses_rs, w_ex.rs,
                               w_mem_writing, w_mem.mem_read, w_mem.dest,
                               w_wb_writing, w_wb.dest);
    assign bus.fwd_b = fwd_sel(w_ex.base.valid, w_ex.uses_rt, w_ex.rt,
                               w_mem_writing, w_mem.mem_read, w_mem.dest,
                               w_wb_writing, w_wb.dest);

    assign w_illegal_a = w_ex.base.valid & w_ex.uses_rs & w_mem_writing &
                         w_mem.mem_read & (w_mem.dest == w_ex.rs);
    assign w_illegal_b = w_ex.base.valid & w_ex.uses_rt & w_mem_writing &
                         w_mem.mem_read & (w_mem.dest == w_ex.rt);

    a_no_mem_load_consumer: assert property (
        @(posedge clk) disable iff (rst) !(w_illegal_a | w_illegal_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // WB's load flag has no consumer once the value is at the register file.
    assign w_unused_wb_mem_read = w_wb.mem_read;

    assign bus.stall       = w_stall;
    assign bus.wb_dest     = w_wb.dest;
    assign bus.wb_we       = w_wb_writing;
    assign bus.stall_count = r_stall_count;
endmodule

// File: tb/tb_dest_reg_hazard_unit.sv
// Directed and randomized checks of dest_reg_hazard_unit against an in-flight instruction queue model.
module tb_dest_reg_hazard_unit;
    import dest_reg_hazard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    dest_reg_hazard_if #(.ADDR_W(5), .CNT_W(16)) bus_a ();
    dest_reg_hazard_if #(.ADDR_W(5), .CNT_W(2))  bus_b ();

    assign bus_b.id_valid     = bus_a.id_valid;
    assign bus_b.id_rs        = bus_a.id_rs;
    assign bus_b.id_rt        = bus_a.id_rt;
    assign bus_b.id_uses_rs   = bus_a.id_uses_rs;
    assign bus_b.id_uses_rt   = bus_a.id_uses_rt;
    assign bus_b.id_dest      = bus_a.id_dest;
    assign bus_b.id_reg_write = bus_a.id_reg_write;
    assign bus_b.id_mem_read  = bus_a.id_mem_read;
    assign bus_b.flush        = bus_a.flush;

    dest_reg_hazard_unit #(.ADDR_W(5), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dest_reg_hazard_unit #(.ADDR_W(5), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        bit         valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        bit         urs;
        bit         urt;
        bit         rw;
        bit         mr;
    } ins_t;

    // pipe_q[0] = EX, [1] = MEM, [2] = WB
    ins_t        pipe_q[$];
    int unsigned stalls;

    function automatic ins_t mk(bit v, logic [4:0] rs, logic [4:0] rt, logic [4:0] d,
                                bit urs, bit urt, bit rw, bit mr);
        ins_t t;
        t.valid = v; t.rs = rs; t.rt = rt; t.dest = d;
        t.urs = urs; t.urt = urt; t.rw = rw; t.mr = mr;
        return t;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic ins_t alu(logic [4:0] d, logic [4:0] rs, logic [4:0] rt);
        return mk(1, rs, rt, d, 1, 1, 1, 0);
    endfunction

    function automatic ins_t lw(logic [4:0] d, logic [4:0] base);
        return mk(1, base, d, d, 1, 0, 1, 1);
    endfunction

    function automatic bit writes(ins_t e);
        return e.valid && e.rw && (e.dest != 0);
    endfunction

    function automatic logic [1:0] exp_fwd(bit use_x, logic [4:0] src);
        if (!use_x) return 2'b00;
        if (writes(pipe_q[1]) && pipe_q[1].dest == src) return pipe_q[1].mr ? 2'b00 : 2'b01;
        if (writes(pipe_q[2]) && pipe_q[2].dest == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit exp_stall(ins_t id, bit fl);
        ins_t ex;
        bit   hz;
        ex = pipe_q[0];
        hz = id.valid && writes(ex) && ex.mr &&
             ((id.urs && id.rs == ex.dest) || (id.urt && id.rt == ex.dest));
        return hz && !fl;
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        repeat (3) pipe_q.push_back(nop());
        stalls = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(bit st);
        logic [31:0] ca;
        logic [31:0] cb;
        ca = (stalls > 65535) ? 65535 : stalls;
        cb = (stalls > 3) ? 3 : stalls;
        chk("stall_a", bus_a.stall, st);
        chk("stall_b", bus_b.stall, st);
        chk("fwd_a", bus_a.fwd_a, exp_fwd(pipe_q[0].valid && pipe_q[0].urs, pipe_q[0].rs));
        chk("fwd_b", bus_a.fwd_b, exp_fwd(pipe_q[0].valid && pipe_q[0].urt, pipe_q[0].rt));
        chk("wb_we", bus_a.wb_we, writes(pipe_q[2]));
        if (pipe_q[2].valid) chk("wb_dest", bus_a.wb_dest, pipe_q[2].dest);
        chk("count_16", bus_a.stall_count, ca);
        chk("count_2", bus_b.stall_count, cb);
    endtask

    task automatic drive(ins_t in, bit fl);
        bus_a.id_valid     = in.valid;
        bus_a.id_rs        = in.rs;
        bus_a.id_rt        = in.rt;
        bus_a.id_uses_rs   = in.urs;
        bus_a.id_uses_rt   = in.urt;
        bus_a.id_dest      = in.dest;
        bus_a.id_reg_write = in.rw;
        bus_a.id_mem_read  = in.mr;
        bus_a.flush        = fl;
    endtask

    // Called just after a rising edge; holds the instruction in ID while a stall is expected.
    task automatic issue(ins_t in, bit fl);
        bit st;
        for (int k = 0; k < 2; k++) begin
            drive(in, fl);
            @(negedge clk);
            st = exp_stall(in, fl);
            check_outputs(st);
            @(posedge clk);
            #1;
            pipe_q.push_front((fl || st) ? nop() : in);
            void'(pipe_q.pop_back());
            if (st) stalls++;
            if (!st) break;
        end
    endtask

    initial begin
        ins_t r;
        bit   fl;

        rst = 1'b1;
        drive(nop(), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU chain, back-to-back then with one nop between
        issue(alu(3, 1, 2), 0);
        issue(alu(4, 3, 5), 0);
        chk("alu_fwd_exmem", bus_a.fwd_a, FWD_EXMEM);
        issue(alu(3, 1, 2), 0);
        issue(nop(), 0);
        issue(alu(4, 3, 5), 0);
        chk("alu_fwd_memwb", bus_a.fwd_a, FWD_MEMWB);

        // Load-use: one stall, then forward from WB
        issue(lw(2, 1), 0);
        issue(alu(6, 2, 7), 0);
        chk("lu_fwd_memwb", bus_a.fwd_a, FWD_MEMWB);
        chk("lu_count", bus_a.stall_count, 1);

        // Register $0 never matches; unused rt never stalls
        issue(alu(0, 1, 2), 0);
        issue(alu(5, 0, 0), 0);
        chk("zero_fwd_a", bus_a.fwd_a, FWD_NONE);
        chk("zero_fwd_b", bus_a.fwd_b, FWD_NONE);
        issue(lw(0, 1), 0);
        issue(alu(5, 0, 1), 0);
        issue(lw(2, 1), 0);
        issue(mk(1, 1, 2, 0, 1, 0, 0, 0), 0);
        chk("no_use_count", bus_a.stall_count, 1);

        // Same dest in MEM and WB: MEM wins
        issue(alu(8, 1, 2), 0);
        issue(alu(8, 3, 4), 0);
        issue(alu(9, 8, 8), 0);
        chk("prio_fwd_a", bus_a.fwd_a, FWD_EXMEM);
        chk("prio_fwd_b", bus_a.fwd_b, FWD_EXMEM);

        // Flush beats a pending load-use stall
        issue(lw(10, 1), 0);
        issue(alu(11, 10, 1), 1);
        chk("flush_count", bus_a.stall_count, 1);
        chk("flush_bubble", bus_a.fwd_a, FWD_NONE);

        // Writeback three edges after ID
        issue(lw(9, 1), 0);
        issue(nop(), 0);
        issue(nop(), 0);
        chk("wb_dest_9", bus_a.wb_dest, 9);
        chk("wb_we_9", bus_a.wb_we, 1);

        // Five more stalls: 16-bit counter reaches 6, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            issue(lw(2, 1), 0);
            issue(alu(3, 2, 2), 0);
        end
        chk("sat_count_16", bus_a.stall_count, 6);
        chk("sat_count_2", bus_b.stall_count, 3);

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            r.valid = ($urandom_range(0, 99) < 85);
            r.rs    = 5'($urandom_range(0, 7));
            r.rt    = 5'($urandom_range(0, 7));
            r.dest  = 5'($urandom_range(0, 7));
            r.urs   = 1'($urandom_range(0, 1));
            r.urt   = 1'($urandom_range(0, 1));
            r.rw    = ($urandom_range(0, 3) != 0);
            r.mr    = r.rw && ($urandom_range(0, 2) == 0);
            fl      = ($urandom_range(0, 9) == 0);
            issue(r, fl);
        end

        // Reset with instructions in flight
        issue(lw(12, 1), 0);
        issue(alu(13, 1, 2), 0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_wb_we", bus_a.wb_we, 0);
        chk("mid_rst_count", bus_a.stall_count, 0);
        chk("mid_rst_fwd_a", bus_a.fwd_a, FWD_NONE);
        drive(nop(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) issue(nop(), 0);
        chk("post_rst_wb_we", bus_a.wb_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
